// File: rtl/rng_pkg.sv
// rng_pkg: shared definitions for the random-number arbiter.
//   - RNG_W          : width of the shared LFSR word
//   - STEPS_DEFAULT  : default number of LFSR advances per grant
//   - state_t        : arbiter FSM encoding (IDLE=0, STEP=1, CAPTURE=2, DONE=3)
package rng_pkg;

  localparam int RNG_W         = 32;
  localparam int STEPS_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_STEP    = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin priority select.
// Searches req starting at ptr and wrapping modulo N; reports whether any
// bit is set and the index of the first one found.
//   req [N-1:0] in  : request vector
//   ptr [W-1:0] in  : highest-priority index this round (must be < N)
//   any         out : req != 0
//   idx [W-1:0] out : selected index (0 when any=0)
// Shared with the other resource arbiters (sound, sprite DMA).
module rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         any,
  output logic [W-1:0] idx
);

  logic [W-1:0] j;

  // Walk from the lowest priority position back to ptr so the last hit,
  // which is the one closest to ptr, wins.
  always_comb begin
    any = 1'b0;
    idx = '0;
    j   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = W'((int'(ptr) + k) % N);
      if (req[j]) begin
        any = 1'b1;
        idx = j;
      end
    end
  end

endmodule

// File: rtl/rng_arbiter.sv
// rng_arbiter: shares one external 32-bit LFSR among N_REQ requesters.
// A round-robin winner is chosen in IDLE, the LFSR is stepped STEPS times,
// the LFSR word is captured and handed out with a one-cycle grant pulse.
//
// Handshake: req is a level request. A transaction, once started, always
// finishes with gnt/rnd_valid high for exactly one cycle; rnd_data is valid
// in that cycle and holds until the next capture. Requesters drop req on the
// edge that ends the grant cycle. Requests are only sampled in IDLE.
//
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   req      [N_REQ-1:0]: per-requester level request
//   gnt      [N_REQ-1:0]: one-hot grant pulse
//   rnd_data [31:0]     : captured random word
//   rnd_valid           : |gnt
//   busy                : high outside IDLE
//   lfsr_en             : step enable to the LFSR
//   lfsr_out [31:0]     : current LFSR state
//
// Build option: RNG_FREERUN_EN -- when defined the LFSR runs in every state
// except CAPTURE (player-timing dependent output); when undefined it only
// runs in STEP, giving a sequence that is deterministic from LFSR reset.
module rng_arbiter
  import rng_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int STEPS = STEPS_DEFAULT,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [RNG_W-1:0] rnd_data,
  output logic             rnd_valid,
  output logic             busy,
  output logic             lfsr_en,
  input  logic [RNG_W-1:0] lfsr_out
);

  localparam int IDX_W = $clog2(N_REQ);

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] cnt;
  logic             pick_any;
  logic [IDX_W-1:0] pick_idx;

  rr_pick #(
    .N (N_REQ),
    .W (IDX_W)
  ) u_pick (
    .req (req),
    .ptr (ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      idx       <= '0;
      cnt       <= '0;
      gnt       <= '0;
      rnd_valid <= 1'b0;
      rnd_data  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            idx   <= pick_idx;
            cnt   <= CNT_W'(STEPS - 1);
            state <= ST_STEP;
          end
        end
        ST_STEP: begin
          // cnt starts at STEPS-1, so STEP lasts exactly STEPS cycles.
          if (cnt == '0) begin
            state <= ST_CAPTURE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_CAPTURE: begin
          rnd_data  <= lfsr_out;
          gnt       <= N_REQ'(1) << idx;
          rnd_valid <= 1'b1;
          ptr       <= (idx == IDX_W'(N_REQ - 1)) ? '0 : idx + 1'b1;
          state     <= ST_DONE;
        end
        ST_DONE: begin
          gnt       <= '0;
          rnd_valid <= 1'b0;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state != ST_IDLE);

`ifdef RNG_FREERUN_EN
  // Gated by rst so the enable is low while the block is held in reset.
  assign lfsr_en = (state != ST_CAPTURE) && !rst;
`else
  assign lfsr_en = (state == ST_STEP);
`endif

endmodule

// File: tb/tb_rng_arbiter.sv
// tb_rng_arbiter: self-checking bench for rng_arbiter (N_REQ=4, STEPS=8).
// Provides the external LFSR, a transaction-timeline reference model, a
// table of directed grant vectors, hand-written corner sequences and a
// randomized phase.
module tb_rng_arbiter;

  localparam int N_REQ = 4;
  localparam int STEPS = 8;
  localparam int CNT_W = 8;
  localparam int LAT   = STEPS + 2;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             lfsr_rst = 1'b0;
  logic [N_REQ-1:0] req = '0;
  logic [N_REQ-1:0] gnt;
  logic [31:0]      rnd_data;
  logic             rnd_valid;
  logic             busy;
  logic             lfsr_en;
  logic [31:0]      lfsr_out;
  logic [31:0]      lfsr_q;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  rng_arbiter #(
    .N_REQ (N_REQ),
    .STEPS (STEPS),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .rnd_data  (rnd_data),
    .rnd_valid (rnd_valid),
    .busy      (busy),
    .lfsr_en   (lfsr_en),
    .lfsr_out  (lfsr_out)
  );

  // External LFSR: right-shifting Fibonacci form. Seed 1 reaches
  // 32'h13000000 after eight steps.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {^(s & 32'hEA000001), s[31:1]};
  endfunction

  always @(posedge clk or posedge lfsr_rst) begin
    if (lfsr_rst) lfsr_q <= 32'h1;
    else if (lfsr_en) lfsr_q <= lfsr_next(lfsr_q);
  end
  assign lfsr_out = lfsr_q;

  // ---------------- reference model ----------------
  // m_t = position in the current transaction: 0 idle, 1..STEPS stepping,
  // STEPS+1 capture cycle, STEPS+2 grant cycle.
  int          m_t = 0;
  int          m_ptr = 0;
  int          m_idx = 0;
  logic [31:0] m_data = '0;
  logic [31:0] m_lfsr = 32'h1;

  function automatic int rr_ref(input logic [N_REQ-1:0] r, input int p);
    for (int k = 0; k < N_REQ; k++) begin
      if (r[(p + k) % N_REQ]) return (p + k) % N_REQ;
    end
    return 0;
  endfunction

  function automatic logic exp_en(input int t, input logic r);
`ifdef RNG_FREERUN_EN
    return !r && (t != STEPS + 1);
`else
    return (t >= 1) && (t <= STEPS);
`endif
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_t <= 0; m_ptr <= 0; m_idx <= 0; m_data <= '0;
    end else if (m_t == 0) begin
      if (req != '0) begin
        m_idx <= rr_ref(req, m_ptr);
        m_t   <= 1;
      end
    end else if (m_t == STEPS + 1) begin
      m_data <= m_lfsr;
      m_ptr  <= (m_idx + 1) % N_REQ;
      m_t    <= m_t + 1;
    end else if (m_t == STEPS + 2) begin
      m_t <= 0;
    end else begin
      m_t <= m_t + 1;
    end
  end

  always @(posedge clk or posedge lfsr_rst) begin
    if (lfsr_rst) m_lfsr <= 32'h1;
    else if (exp_en(m_t, rst)) m_lfsr <= lfsr_next(m_lfsr);
  end

  // ---------------- checking helpers ----------------
  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    logic [N_REQ-1:0] eg;
    logic [N_REQ+34:0] act, exp;
    eg  = (m_t == STEPS + 2) ? (N_REQ'(1) << m_idx) : '0;
    act = {gnt, rnd_valid, busy, lfsr_en, rnd_data};
    exp = {eg, |eg, (m_t != 0), exp_en(m_t, rst), m_data};
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL model: gnt/valid/busy/en/data got %b %b %b %b %h expected %b %b %b %b %h at %0t",
               gnt, rnd_valid, busy, lfsr_en, rnd_data,
               eg, |eg, (m_t != 0), exp_en(m_t, rst), m_data, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_model();
  endtask

  // Waits (bounded) for a grant pulse; lat counts clock edges from the call.
  task automatic wait_gnt(input string name, output int lat, output logic [N_REQ-1:0] g);
    lat = 0;
    g   = '0;
    for (int c = 0; c < 4 * LAT; c++) begin
      tick();
      lat++;
      if (gnt != '0) begin
        g = gnt;
        return;
      end
    end
    vectors++;
    miscompares++;
    $display("FAIL %s_timeout: got no gnt expected a grant within %0d cycles", name, 4 * LAT);
  endtask

  typedef struct {
    logic [N_REQ-1:0] req_in;
    logic [N_REQ-1:0] exp_gnt;
  } vec_t;

  vec_t             tbl[12];
  logic [N_REQ-1:0] exp_q[$];
  int               lat;
  logic [N_REQ-1:0] g;

  initial begin
    // Table assumes ptr=0 at the first record.
    tbl[0]  = '{4'b0001, 4'b0001};
    tbl[1]  = '{4'b1111, 4'b0010};
    tbl[2]  = '{4'b1111, 4'b0100};
    tbl[3]  = '{4'b1111, 4'b1000};
    tbl[4]  = '{4'b1111, 4'b0001};
    tbl[5]  = '{4'b0001, 4'b0001};
    tbl[6]  = '{4'b1000, 4'b1000};
    tbl[7]  = '{4'b0110, 4'b0010};
    tbl[8]  = '{4'b0100, 4'b0100};
    tbl[9]  = '{4'b1001, 4'b1000};
    tbl[10] = '{4'b1001, 4'b0001};
    tbl[11] = '{4'b1100, 4'b0100};

    // ---- reset, checked before any clock edge ----
    #1;
    rst = 1'b1;
    lfsr_rst = 1'b1;
    #1;
    check_val("reset_ctrl", {28'd0, gnt}, 32'd0);
    check_val("reset_flags", {29'd0, rnd_valid, busy, lfsr_en}, 32'd0);
    check_val("reset_data", rnd_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    lfsr_rst = 1'b0;

    // ---- directed table ----
    for (int i = 0; i < 12; i++) begin
      tick();
      req = tbl[i].req_in;
      exp_q.push_back(tbl[i].exp_gnt);
      wait_gnt("table", lat, g);
      check_val($sformatf("table%0d_gnt", i), {28'd0, g}, {28'd0, exp_q.pop_front()});
      check_val($sformatf("table%0d_lat", i), lat, LAT);
`ifndef RNG_FREERUN_EN
      if (i == 0) check_val("seed1_data", rnd_data, 32'h13000000);
`endif
      req = '0;
      tick();
      check_val($sformatf("table%0d_oneshot", i), {28'd0, gnt}, 32'd0);
    end

    // ---- abort: async reset mid-STEP ----
    req = 4'b0010;
    repeat (4) tick();
    #2;
    rst = 1'b1;
    #1;
    check_val("abort_ctrl", {27'd0, gnt, rnd_valid}, 32'd0);
    check_val("abort_flags", {30'd0, busy, lfsr_en}, 32'd0);
    check_val("abort_data", rnd_data, 32'd0);
    req = '0;
    tick();
    rst = 1'b0;
    for (int c = 0; c < STEPS + 5; c++) begin
      tick();
      check_val("abort_nognt", {28'd0, gnt}, 32'd0);
    end
    req = 4'b1111;
    wait_gnt("abort_next", lat, g);
    check_val("abort_next_gnt", {28'd0, g}, 32'h1);
    check_val("abort_next_lat", lat, LAT);
    req = '0;
    tick();

    // ---- late drop of req[1] (ptr is 1 here) ----
    req = 4'b0010;
    repeat (3) tick();
    req = '0;
    wait_gnt("late_drop", lat, g);
    check_val("late_drop_gnt", {28'd0, g}, 32'h2);
    check_val("late_drop_lat", lat + 3, LAT);
    tick();
    req = 4'b0111;
    wait_gnt("late_drop_ptr", lat, g);
    check_val("late_drop_ptr_gnt", {28'd0, g}, 32'h4);
    req = '0;
    tick();

    // ---- all requesting from ptr=0 ----
    #2;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      wait_gnt("all_req", lat, g);
      check_val($sformatf("all_req%0d_gnt", n), {28'd0, g}, 32'(1 << (n % 4)));
      check_val($sformatf("all_req%0d_spacing", n), (n == 0) ? lat : lat + 1,
                (n == 0) ? LAT : STEPS + 3);
      req = req & ~g;
      tick();
      req = 4'b1111;
    end
    req = '0;
    tick();

    // ---- randomized phase against the model ----
    for (int c = 0; c < 1500; c++) begin
      tick();
      if (gnt != '0) begin
        req = req & ~gnt;
      end else begin
        if ($urandom_range(0, 3) == 0) req = req | N_REQ'($urandom_range(0, 15));
        if ($urandom_range(0, 15) == 0) req = req & ~(N_REQ'(1) << $urandom_range(0, 3));
      end
      if ($urandom_range(0, 299) == 0) begin
        #1 rst = 1'b1;
        #2 rst = 1'b0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
